// File: rtl/csa_resolver.sv
// csa_resolver: turns a carry-save pair (sum, carry) into one binary result.
// The carry-propagate add runs over several cycles, CHUNK bits per cycle,
// with a registered carry passed from one chunk to the next.
// There is a valid/ready handshake on both the input and the output side.
// Optional build macro CSA_RESOLVER_ZERO_FLAG_EN adds the registered output
// out_zero, which is 1 when the result is zero.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready=1
// ADD   | resolving chunk idx_q; in_ready=0, out_valid=0
// DONE  | result held for the consumer; in_ready follows out_ready
module csa_resolver #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH:0]   carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam int RW  = WIDTH + 2;
    localparam int NCH = (RW + CHUNK - 1) / CHUNK;
    // Operands and result are padded up to a whole number of chunks, so the
    // last (truncated) chunk needs no special case. The padding bits only
    // ever hold the discarded final carry.
    localparam int EW  = NCH * CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state_q;
    logic [EW-1:0] opa_q, opb_q, res_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic          out_valid_q;
    logic          accept;
    logic [31:0]   bit_off;
    logic [EW-1:0] a_ext, b_ext, cmask, res_next;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;

    // in_ready is combinational so that a DONE->ADD handoff can happen on one edge
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Select the current chunk, add it, and merge it into the result vector
    always_comb begin
        bit_off   = 32'(idx_q) * CHUNK;
        a_ext     = opa_q >> bit_off;
        b_ext     = opb_q >> bit_off;
        a_chunk   = a_ext[CHUNK-1:0];
        b_chunk   = b_ext[CHUNK-1:0];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        cmask     = '0;
        cmask[CHUNK-1:0] = '1;
        res_next  = (res_q & ~(cmask << bit_off)) |
                    (EW'(chunk_sum[CHUNK-1:0]) << bit_off);
    end

`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    logic zero_acc_q;
    logic out_zero_q;
    logic chunk_zero;

    always_comb chunk_zero = (chunk_sum[CHUNK-1:0] == '0);

    // Running AND of the per-chunk zero flags; its last step lands in out_zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc_q <= 1'b0;
            out_zero_q <= 1'b0;
        end else if (accept) begin
            zero_acc_q <= 1'b1;
        end else if (state_q == ADD) begin
            zero_acc_q <= zero_acc_q & chunk_zero;
            if (idx_q == LAST_IDX) out_zero_q <= zero_acc_q & chunk_zero;
        end
    end

    assign out_zero = out_zero_q;
`endif

    // Controller: operand capture, chunk sequencing and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                opa_q   <= EW'(sum_in);
                opb_q   <= EW'(carry_in);
                idx_q   <= '0;
                carry_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (accept) state_q <= ADD;
                ADD: begin
                    res_q   <= res_next;
                    carry_q <= chunk_sum[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= accept ? ADD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q[RW-1:0];

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and random checks for csa_resolver (WIDTH=10, CHUNK=4, N=3).
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  sum_in;
    logic [10:0] carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] result;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_chk = 0;
    int n_bad = 0;

    csa_resolver #(.WIDTH(10), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Send one pair with out_ready=1 and check the exact 3-cycle latency.
    // Call this right after a clock edge, with the DUT idle.
    task automatic run_one(input string tag, input logic [9:0] s, input logic [10:0] c,
                           input logic [11:0] exp);
        out_ready = 1'b1;
        sum_in    = s;
        carry_in  = c;
        in_valid  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum_in   = '1;
        carry_in = '1;
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) begin
                chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
                chk({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp));
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
        chk({tag, "_zero"}, 32'(out_zero), 32'(exp == 12'd0));
`endif
        @(posedge clk); #1;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [11:0] expq[$];
    logic [11:0] exp_cur;
    logic [9:0]  ra, rb, rc;
    int          acc_cnt, got_cnt, cyc;
    logic        do_acc, do_out;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_one("max",   10'h3FF, 11'h7FE, 12'hBFD);
        run_one("zero",  10'h000, 11'h000, 12'h000);
        run_one("one",   10'h001, 11'h000, 12'h001);
        run_one("cb01",  10'h00F, 11'h001, 12'h010);
        run_one("cb12",  10'h0FF, 11'h001, 12'h100);
        run_one("mixed", 10'h2A5, 11'h35A, 12'h5FF);

        // Backpressure with a same-edge handoff into the next operation
        out_ready = 1'b0;
        sum_in    = 10'h123;
        carry_in  = 11'h000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                sum_in   = 10'h0AA;
                carry_in = 11'h002;
                in_valid = 1'b1;
            end
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(result), 32'h123);
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_handoff_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_after_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_result", 32'(result), 32'h0AC);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of ADD
        sum_in   = 10'h3FF;
        carry_in = 11'h7FE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Random CSA pairs with random gaps on both sides
        acc_cnt = 0;
        got_cnt = 0;
        cyc     = 0;
        while (got_cnt < 1000 && cyc < 30000) begin
            if (!in_valid && acc_cnt < 1000 && $urandom_range(0, 3) != 0) begin
                ra       = 10'($urandom);
                rb       = 10'($urandom);
                rc       = 10'($urandom);
                sum_in   = ra ^ rb ^ rc;
                carry_in = {(ra & rb) | (ra & rc) | (rb & rc), 1'b0};
                exp_cur  = 12'(ra) + 12'(rb) + 12'(rc);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            do_acc = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (do_out) begin
                if (expq.size() == 0) chk("rnd_extra_out", 32'd1, 32'd0);
                else chk("rnd_result", 32'(result), 32'(expq.pop_front()));
            end
            @(posedge clk); #1;
            cyc++;
            if (do_acc) begin
                expq.push_back(exp_cur);
                acc_cnt++;
                in_valid = 1'b0;
            end
            if (do_out) got_cnt++;
        end
        chk("rnd_count", 32'(got_cnt), 32'd1000);
        chk("rnd_leftover", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
